spio_hss_multiplexer_reg_spi: RTL and testbench

SPI-slave bridge that gives an off-chip controller access to the HSS multiplexer register bank. It sits directly upstream of the register bank and is the only master of its access port. It drives `reg_addr`, `reg_write` and `reg_write_data`, and it returns `reg_read_data` serially on `miso`. SPI pins are asynchronous to `clk` and are synchronised internally.

---
 rtl/spio_hss_multiplexer_reg_spi_pkg.sv | 20 ++
 rtl/spio_hss_multiplexer_sync2.sv | 31 +++
 rtl/spio_hss_multiplexer_reg_spi.sv | 167 ++++++++++++++++
 tb/tb_spio_hss_multiplexer_reg_spi.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/spio_hss_multiplexer_reg_spi_pkg.sv
// Shared constants and state encoding for the HSS multiplexer SPI register bridge.
package spio_hss_multiplexer_reg_spi_pkg;

  localparam int CMD_WR_BIT = 7;
  localparam int CMD_BITS   = 8;
  localparam int CNT_BITS   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

  // Total SPI clocks in one frame: command byte followed by the data word.
  function automatic int frame_bits(input int regd_bits);
    return CMD_BITS + regd_bits;
  endfunction

endpackage

// File: rtl/spio_hss_multiplexer_sync2.sv
// Two-flop synchroniser for one asynchronous input; resets to 0.
module spio_hss_multiplexer_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: plain two-stage pipeline.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spio_hss_multiplexer_reg_spi.sv
// SPI slave (mode 0) giving an off-chip controller read/write access to the
// HSS multiplexer register bank. Frame: 8-bit command then REGD_BITS data bits.
module spio_hss_multiplexer_reg_spi
  import spio_hss_multiplexer_reg_spi_pkg::*;
#(
  parameter int REGA_BITS = 5,
  parameter int REGD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 nss,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 reg_write,
  output logic [REGA_BITS-1:0] reg_addr,
  output logic [REGD_BITS-1:0] reg_write_data,
  input  logic [REGD_BITS-1:0] reg_read_data
);

  localparam int FRAME_BITS = frame_bits(REGD_BITS);

  logic sclk_s, mosi_s, nss_n_s, nss_s;

  spio_hss_multiplexer_sync2 u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  spio_hss_multiplexer_sync2 u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));
  // nss goes through inverted so the synchroniser's reset value reads as "deselected".
  spio_hss_multiplexer_sync2 u_sync_nss  (.clk(clk), .rst(rst), .d(~nss), .q(nss_n_s));
  assign nss_s = ~nss_n_s;

  spi_state_e           state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [REGD_BITS-2:0] rx_q, rx_d;
  logic [REGD_BITS-1:0] rx_shift;
  logic [REGD_BITS-1:0] tx_q, tx_d;
  logic                 wr_flag_q, wr_flag_d;
  logic                 cap_q, cap_d;
  logic                 sclk_prev_q, sclk_prev_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [REGA_BITS-1:0] reg_addr_q, reg_addr_d;
  logic [REGD_BITS-1:0] reg_wdata_q, reg_wdata_d;
  logic                 reg_write_q, reg_write_d;
  logic                 miso_q, miso_d;

  // Incoming bit appended to the RX history; the low byte is the command at bit 8.
  assign rx_shift = {rx_q, mosi_s};

  // Registered edge detection on the synchronised SPI clock.
  always_comb begin
    sclk_prev_d = sclk_s;
    rise_d      = sclk_s & ~sclk_prev_q;
    fall_d      = ~sclk_s & sclk_prev_q;
  end

  // Frame FSM, shift registers and register-bank outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    wr_flag_d   = wr_flag_q;
    cap_d       = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_write_d = 1'b0;
    miso_d      = miso_q;

    // reg_addr settled last cycle, so the bank's read data is now valid.
    if (cap_q) tx_d = reg_read_data;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (!nss_s) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
      end
      ST_CMD: begin
        miso_d = 1'b0;
        if (rise_q) begin
          rx_d  = rx_shift[REGD_BITS-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_BITS'(CMD_BITS - 1)) begin
            reg_addr_d = rx_shift[REGA_BITS-1:0];
            wr_flag_d  = rx_shift[CMD_WR_BIT];
            cap_d      = ~rx_shift[CMD_WR_BIT];
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rise_q) begin
          rx_d  = rx_shift[REGD_BITS-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_BITS'(FRAME_BITS - 1)) begin
            if (wr_flag_q) begin
              reg_wdata_d = rx_shift;
              reg_write_d = 1'b1;
            end
            state_d = ST_DONE;
          end
        end
        // Reads shift TX out MSB first on falling edges; writes keep miso low.
        if (fall_q) begin
          miso_d = wr_flag_q ? 1'b0 : tx_q[REGD_BITS-1];
          tx_d   = {tx_q[REGD_BITS-2:0], 1'b0};
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    // Deselect ends the frame from any state; an unfinished write is dropped.
    if (nss_s && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      miso_d      = 1'b0;
      reg_write_d = 1'b0;
      reg_wdata_d = reg_wdata_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      wr_flag_q   <= 1'b0;
      cap_q       <= 1'b0;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_write_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      wr_flag_q   <= wr_flag_d;
      cap_q       <= cap_d;
      sclk_prev_q <= sclk_prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_write_q <= reg_write_d;
      miso_q      <= miso_d;
    end
  end

  assign miso           = miso_q;
  assign reg_write      = reg_write_q;
  assign reg_addr       = reg_addr_q;
  assign reg_write_data = reg_wdata_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_reg_spi.sv
// Directed bench for the HSS multiplexer SPI register bridge.
module tb_spio_hss_multiplexer_reg_spi;

  localparam int HP = 100;  // sclk half period in ns (10 clk)

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, nss, mosi, miso;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_write_data, reg_read_data;

  logic [31:0] mem [32];
  int          wr_cnt = 0;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  int          n_cmp = 0;
  int          n_bad = 0;

  spio_hss_multiplexer_reg_spi #(.REGA_BITS(5), .REGD_BITS(32)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .nss(nss), .mosi(mosi), .miso(miso),
    .reg_write(reg_write), .reg_addr(reg_addr), .reg_write_data(reg_write_data),
    .reg_read_data(reg_read_data)
  );

  always #5 clk = ~clk;

  // Register bank model: address 0 is a fixed pattern, the rest loop back writes.
  always @(posedge clk) if (reg_write) mem[reg_addr] <= reg_write_data;
  assign reg_read_data = (reg_addr == 5'd0) ? 32'h0001_0002 : mem[reg_addr];

  // Count strobe cycles and remember what each strobe presented.
  always @(negedge clk) begin
    if (reg_write) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= reg_addr;
      wr_data <= reg_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One SPI frame: nbits clocks of {cmd,data} MSB first (zeros past 40 bits).
  // rst_at >= 0 pulses rst before that bit and abandons the frame.
  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] data,
                           input int nbits, input int rst_at, input int gap,
                           output logic [31:0] rd, output logic extra);
    logic [39:0] word;
    word  = {cmd, data};
    rd    = '0;
    extra = 1'b0;
    nss   = 1'b0;
    #(HP);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #25;
        rst = 1'b0;
        break;
      end
      mosi = (i < 40) ? word[39 - i] : 1'b0;
      #(HP);
      sclk = 1'b1;
      if (i >= 8 && i < 40) rd = {rd[30:0], miso};
      if (i >= 40) extra = extra | miso;
      #(HP);
      sclk = 1'b0;
    end
    #(HP);
    nss  = 1'b1;
    mosi = 1'b0;
    #(gap);
  endtask

  initial begin
    logic [31:0] rd;
    logic        ex;
    int          c0;
    rst = 1'b1; sclk = 1'b0; nss = 1'b1; mosi = 1'b0;
    #35 rst = 1'b0;
    #50;
    check("rst_reg_write", {31'd0, reg_write}, 32'd0);
    check("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
    check("rst_wdata", reg_write_data, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);

    // Write 0x14 = 0xABC
    c0 = wr_cnt;
    spi_frame(8'h94, 32'h0000_0ABC, 40, -1, 200, rd, ex);
    check("wr_count", wr_cnt - c0, 1);
    check("wr_addr", {27'd0, wr_addr}, 32'h14);
    check("wr_data", wr_data, 32'h0000_0ABC);
    check("wr_miso_zero", rd, 32'd0);

    // Read 0x00
    c0 = wr_cnt;
    spi_frame(8'h00, 32'h0, 40, -1, 200, rd, ex);
    check("rd_data", rd, 32'h0001_0002);
    check("rd_no_strobe", wr_cnt - c0, 0);
    check("rd_addr", {27'd0, reg_addr}, 32'h0);

    // Abort a write to 0x0A after 20 bits
    c0 = wr_cnt;
    spi_frame(8'h8A, 32'h1234_5678, 20, -1, 200, rd, ex);
    check("abort_no_strobe", wr_cnt - c0, 0);
    check("abort_wdata_hold", reg_write_data, 32'h0000_0ABC);
    check("abort_addr_loaded", {27'd0, reg_addr}, 32'h0A);
    spi_frame(8'h98, 32'h0000_0001, 40, -1, 200, rd, ex);
    check("post_abort_count", wr_cnt - c0, 1);
    check("post_abort_addr", {27'd0, wr_addr}, 32'h18);
    check("post_abort_data", wr_data, 32'h1);

    // Back-to-back: write 0x15 = 3, 4-clk gap, read it back
    c0 = wr_cnt;
    spi_frame(8'h95, 32'h0000_0003, 40, -1, 40, rd, ex);
    spi_frame(8'h15, 32'h0, 40, -1, 200, rd, ex);
    check("b2b_count", wr_cnt - c0, 1);
    check("b2b_readback", rd, 32'h0000_0003);

    // Overrun: 45 clocks in a write frame
    c0 = wr_cnt;
    spi_frame(8'h83, 32'hCAFE_F00D, 45, -1, 200, rd, ex);
    check("ovr_count", wr_cnt - c0, 1);
    check("ovr_addr", {27'd0, wr_addr}, 32'h03);
    check("ovr_data", wr_data, 32'hCAFE_F00D);
    check("ovr_extra_miso", {31'd0, ex}, 32'd0);

    // Reset at bit 30 of a write
    c0 = wr_cnt;
    spi_frame(8'h8C, 32'h55AA_55AA, 40, 30, 200, rd, ex);
    check("rstmid_no_strobe", wr_cnt - c0, 0);
    check("rstmid_addr", {27'd0, reg_addr}, 32'd0);
    check("rstmid_wdata", reg_write_data, 32'd0);
    check("rstmid_miso", {31'd0, miso}, 32'd0);
    spi_frame(8'h87, 32'hDEAD_BEEF, 40, -1, 200, rd, ex);
    check("rstmid_next_count", wr_cnt - c0, 1);
    check("rstmid_next_addr", {27'd0, wr_addr}, 32'h07);
    check("rstmid_next_data", wr_data, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
